// File: rtl/iq_sample_framer_if.sv
// Frame/pair handshake bundle between the I/Q sample framer and the downstream mux2 pair selector.
interface iq_sample_framer_if #(
    parameter int unsigned SAMPLE_W = 5,
    parameter int unsigned SEL_W    = 3
);
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_sample;
    logic                in_ready;
    logic [SAMPLE_W-1:0] samp_0;
    logic [SAMPLE_W-1:0] samp_1;
    logic [SAMPLE_W-1:0] samp_2;
    logic [SAMPLE_W-1:0] samp_3;
    logic [SAMPLE_W-1:0] samp_4;
    logic [SAMPLE_W-1:0] samp_5;
    logic [SAMPLE_W-1:0] samp_6;
    logic [SAMPLE_W-1:0] samp_7;
    logic [SAMPLE_W-1:0] samp_8;
    logic [SAMPLE_W-1:0] samp_9;
    logic [SEL_W-1:0]    sel;
    logic                pair_valid;
    logic                pair_ready;
    logic                frame_start;

    modport master (
        input  in_valid, in_sample, pair_ready,
        output in_ready, samp_0, samp_1, samp_2, samp_3, samp_4,
               samp_5, samp_6, samp_7, samp_8, samp_9,
               sel, pair_valid, frame_start
    );

    modport slave (
        output in_valid, in_sample, pair_ready,
        input  in_ready, samp_0, samp_1, samp_2, samp_3, samp_4,
               samp_5, samp_6, samp_7, samp_8, samp_9,
               sel, pair_valid, frame_start
    );
endinterface

// File: rtl/iq_sample_framer.sv
// Ping-pong framer: packs I/Q samples into 10-sample frames and steps the mux2 pair select 0..4.
// Optional frame_cnt/stall_flag outputs are enabled by defining IQ_FRAMER_STATS_EN.
module iq_sample_framer #(
    parameter int unsigned SAMPLE_W   = 5,
    parameter int unsigned NB_SAMPLES = 10,
    parameter int unsigned SEL_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    iq_sample_framer_if.master bus
`ifdef IQ_FRAMER_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic               stall_flag
`endif
);
    localparam int unsigned      CNT_W    = $clog2(NB_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(NB_SAMPLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NB_SAMPLES / 2 - 1);

    typedef enum logic {IDLE, DRAIN} rd_state_e;
    typedef logic [SAMPLE_W-1:0] sample_t;

    sample_t          banks_q [2][NB_SAMPLES];
    sample_t          banks_d [2][NB_SAMPLES];
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_full_q, wr_full_d;
    rd_state_e        state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             frame_start_q, frame_start_d;

    logic             wr_bank;
    logic             accept;
    logic             pair_fire;
    logic             swap;

    assign wr_bank   = ~rd_bank_q;
    assign accept    = bus.in_valid && !wr_full_q;
    assign pair_fire = (state_q == DRAIN) && bus.pair_ready;
    // Uses the registered wr_full, so a 10th-sample accept coinciding with the last pair cannot swap.
    assign swap      = wr_full_q && ((state_q == IDLE) || (pair_fire && sel_q == LAST_SEL));

    always_comb begin
        banks_d       = banks_q;
        rd_bank_d     = rd_bank_q;
        wr_cnt_d      = wr_cnt_q;
        wr_full_d     = wr_full_q;
        state_d       = state_q;
        sel_d         = sel_q;
        frame_start_d = 1'b0;

        if (accept) begin
            banks_d[wr_bank][wr_cnt_q] = bus.in_sample;
            if (wr_cnt_q == LAST_WR) begin
                wr_cnt_d  = '0;
                wr_full_d = 1'b1;
            end else begin
                wr_cnt_d  = wr_cnt_q + 1'b1;
            end
        end

        if (swap) begin
            rd_bank_d     = ~rd_bank_q;
            wr_full_d     = 1'b0;
            sel_d         = '0;
            state_d       = DRAIN;
            frame_start_d = 1'b1;
        end else if (pair_fire) begin
            if (sel_q == LAST_SEL) begin
                sel_d   = '0;
                state_d = IDLE;
            end else begin
                sel_d   = sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            banks_q       <= '{default: '0};
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            wr_full_q     <= 1'b0;
            state_q       <= IDLE;
            sel_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            banks_q       <= banks_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_full_q     <= wr_full_d;
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.in_ready    = !wr_full_q;
    assign bus.pair_valid  = (state_q == DRAIN);
    assign bus.sel         = sel_q;
    assign bus.frame_start = frame_start_q;
    assign bus.samp_0      = banks_q[rd_bank_q][0];
    assign bus.samp_1      = banks_q[rd_bank_q][1];
    assign bus.samp_2      = banks_q[rd_bank_q][2];
    assign bus.samp_3      = banks_q[rd_bank_q][3];
    assign bus.samp_4      = banks_q[rd_bank_q][4];
    assign bus.samp_5      = banks_q[rd_bank_q][5];
    assign bus.samp_6      = banks_q[rd_bank_q][6];
    assign bus.samp_7      = banks_q[rd_bank_q][7];
    assign bus.samp_8      = banks_q[rd_bank_q][8];
    assign bus.samp_9      = banks_q[rd_bank_q][9];

`ifdef IQ_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic        stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            if (swap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (bus.in_valid && wr_full_q) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign stall_flag = stall_q;
`endif
endmodule

// File: tb/tb_iq_sample_framer.sv
// Bench for iq_sample_framer: directed scenarios plus random traffic against a frame-queue model.
module tb_iq_sample_framer;
    logic clk;
    logic rst;

    iq_sample_framer_if #(.SAMPLE_W(5), .SEL_W(3)) bus ();

`ifdef IQ_FRAMER_STATS_EN
    logic [15:0] frame_cnt;
    logic        stall_flag;
`endif

    iq_sample_framer #(.SAMPLE_W(5), .NB_SAMPLES(10), .SEL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IQ_FRAMER_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .stall_flag (stall_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted sample in order; frame k is samples[10k..10k+9].
    logic [4:0] samples[$];
    int         n_acc;
    int         n_pres;
    int         pairs;
    logic       fs_m;
    logic       stall_m;
    logic [4:0] nxt;
    bit         seq;

    task automatic model_clear();
        samples.delete();
        n_acc   = 0;
        n_pres  = 0;
        pairs   = 0;
        fs_m    = 1'b0;
        stall_m = 1'b0;
    endtask

    function automatic bit m_full();
        return (n_acc - 10 * n_pres) == 10;
    endfunction

    function automatic bit m_busy();
        return pairs < 5 * n_pres;
    endfunction

    task automatic check_outputs();
        logic [49:0] exp_pack;
        logic [49:0] got_pack;
        exp_pack = '0;
        for (int k = 0; k < 10; k++) begin
            if (n_pres > 0) exp_pack[k*5 +: 5] = samples[10 * (n_pres - 1) + k];
        end
        got_pack = {bus.samp_9, bus.samp_8, bus.samp_7, bus.samp_6, bus.samp_5,
                    bus.samp_4, bus.samp_3, bus.samp_2, bus.samp_1, bus.samp_0};
        check_eq("in_ready", 64'(bus.in_ready), 64'(!m_full()));
        check_eq("pair_valid", 64'(bus.pair_valid), 64'(m_busy()));
        check_eq("sel", 64'(bus.sel), m_busy() ? 64'(pairs % 5) : 64'd0);
        check_eq("samp", 64'(got_pack), 64'(exp_pack));
        check_eq("frame_start", 64'(bus.frame_start), 64'(fs_m));
`ifdef IQ_FRAMER_STATS_EN
        check_eq("frame_cnt", 64'(frame_cnt), 64'(n_pres % 65536));
        check_eq("stall_flag", 64'(stall_flag), 64'(stall_m));
`endif
    endtask

    // Called one time unit after a rising edge; drives inputs, advances one clock, checks outputs.
    task automatic cycle(input logic v, input logic pr);
        bit full, busy, fire, swp, acc;
        bus.in_valid   = v;
        bus.in_sample  = nxt;
        bus.pair_ready = pr;
        full = m_full();
        busy = m_busy();
        fire = busy && pr;
        swp  = full && (!busy || (fire && (pairs % 5) == 4));
        acc  = v && !full;
        if (v && full) stall_m = 1'b1;
        @(posedge clk);
        #1;
        if (fire) pairs++;
        if (swp) n_pres++;
        if (acc) begin
            samples.push_back(nxt);
            n_acc++;
            nxt = seq ? nxt + 5'd1 : 5'($urandom_range(0, 31));
        end
        fs_m = swp;
        check_outputs();
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.pair_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit reached;
        int hold;
        rst = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus.pair_ready = 1'b0;
        seq = 1'b1;
        nxt = 5'd1;
        model_clear();
        @(posedge clk);
        #1;

        // 1: one frame of 1..10, downstream always ready
        do_reset();
        nxt = 5'd1;
        for (int c = 0; c < 20; c++) cycle(n_acc < 10, 1'b1);
        check_eq("t1_samp0", 64'(bus.samp_0), 64'd1);
        check_eq("t1_samp9", 64'(bus.samp_9), 64'd10);

        // 2: stall 5 cycles at sel==2
        do_reset();
        nxt  = 5'd1;
        hold = 0;
        for (int c = 0; c < 30; c++) begin
            if (m_busy() && (pairs % 5) == 2 && hold < 5) begin
                hold++;
                cycle(n_acc < 10, 1'b0);
            end else begin
                cycle(n_acc < 10, 1'b1);
            end
        end

        // 3: 30 samples with downstream stalled, then released
        do_reset();
        nxt = 5'd0;
        for (int c = 0; c < 40; c++) cycle(n_acc < 30, 1'b0);
        check_eq("t3_blocked", 64'(bus.in_ready), 64'd0);
        for (int c = 0; c < 60; c++) cycle(n_acc < 30, 1'b1);
        check_eq("t3_last0", 64'(bus.samp_0), 64'd20);
        check_eq("t3_last9", 64'(bus.samp_9), 64'd29);

        // 4: reset after 6 samples, then again mid-drain at sel==3
        do_reset();
        nxt = 5'd1;
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1);
        do_reset();
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            cycle(n_acc < 10, 1'b1);
            if (m_busy() && (pairs % 5) == 3) reached = 1'b1;
        end
        check_eq("t4_reach_sel3", 64'(reached), 64'd1);
        do_reset();
        nxt = 5'd11;
        for (int c = 0; c < 20; c++) cycle(n_acc < 10, 1'b1);
        check_eq("t4_clean0", 64'(bus.samp_0), 64'd11);
        check_eq("t4_clean9", 64'(bus.samp_9), 64'd20);

        // 5: three frames with an in_valid while blocked
        do_reset();
        nxt = 5'd0;
        for (int c = 0; c < 25; c++) cycle(n_acc < 30, 1'b0);
        for (int c = 0; c < 50; c++) cycle(n_acc < 30, 1'b1);
`ifdef IQ_FRAMER_STATS_EN
        check_eq("t5_frame_cnt", 64'(frame_cnt), 64'd3);
        check_eq("t5_stall", 64'(stall_flag), 64'd1);
`endif

        // Random traffic
        do_reset();
        seq = 1'b0;
        nxt = 5'($urandom_range(0, 31));
        for (int c = 0; c < 2000; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/iq_sample_framer.md
Name: iq_sample_framer

Overview:
- Upstream stage of the iq_demod pair selector.
- Accepts a stream of 5-bit I/Q samples and groups them into frames of 10.
- Presents each frame on ten parallel sample buses to the downstream mux2 (in_0..in_9).
- Steps that selector's 3-bit `sel` through 0..4 with a valid/ready handshake.
- Ping-pong banked, so input can keep arriving while the previous frame drains.

Parameters:
- SAMPLE_W, 5, sample width in bits; must match the mux2 data width.
- NB_SAMPLES, 10, samples per frame; fixed by the mux2 input count. Other values are unsupported.
- SEL_W, 3, width of the pair-select output.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_sample is valid
- in_sample  input  SAMPLE_W  incoming sample
- in_ready  output  1  framer can accept a sample this cycle
- samp_0 .. samp_9  output  SAMPLE_W each  read-bank samples, in arrival order; feed mux2 in_0..in_9
- sel  output  SEL_W  pair index; feeds mux2 sel
- pair_valid  output  1  mux2 outputs for the current sel are valid
- pair_ready  input  1  downstream consumed the current pair
- frame_start  output  1  one-cycle pulse, first cycle a new frame is presented

Behaviour:
- Reset (async assert, sync release):
  - wr_cnt=0, wr_full=0, read state IDLE, sel=0, pair_valid=0, frame_start=0.
  - samp_0..samp_9=0; both banks cleared.
- Write side:
  - in_ready = !wr_full, combinational from the register.
  - Accept happens when in_valid && in_ready. The sample is written to write-bank slot wr_cnt, then wr_cnt increments.
  - When the accepted sample is the 10th (wr_cnt==9): wr_cnt goes to 0 and wr_full goes to 1.
- Swap condition, evaluated each edge: wr_full && (rd_state==IDLE || (rd_state==DRAIN && sel==4 && pair_valid && pair_ready)).
- On swap:
  - Bank roles exchange; samp_x now shows the just-filled bank.
  - wr_full clears; sel goes to 0; rd_state goes to DRAIN; frame_start pulses high in the following cycle.
- Read state machine:
  - IDLE: pair_valid=0, sel=0, samp_x hold the last drained frame.
    - Exit: swap takes it to DRAIN.
  - DRAIN: pair_valid=1.
    - On pair_valid && pair_ready with sel<4: sel increments.
    - sel==4 with pair accepted: swap if its condition holds (back-to-back frame, sel goes to 0); otherwise go to IDLE with sel=0.
    - pair_ready low: sel and samp_x hold stable.
- sel never takes values 5..7.
- Latency:
  - The 10th sample is accepted at edge E; with read IDLE, the swap occurs at E+1 and pair_valid is high from E+1.
  - in_ready is low for exactly one cycle between frames when the read side is idle.
- Simultaneous events: the 10th-sample accept and the final pair acceptance at the same edge do not swap. wr_full is set at that edge, the read side goes IDLE, and the swap occurs at the next edge.
- Backpressure: if downstream stalls, wr_full stays 1 and in_ready stays 0. No sample is ever dropped or overwritten.
- Reset mid-frame: partially written and partially drained frames are discarded; outputs return to their reset values immediately.

Optional Feature:
- Macro IQ_FRAMER_STATS_EN.
- When defined:
  - Adds output frame_cnt, 16 bits.
  - frame_cnt increments on every swap and wraps from 0xFFFF to 0; reset value 0.
  - Adds output stall_flag, 1 bit, sticky. It is set when in_valid && !in_ready, and cleared only by rst.
- When undefined: neither port exists and no related logic is generated. Core behaviour is identical.

Test Plan:
1. Reset, then feed samples 1..10 with in_valid held high and pair_ready=1:
   - samp_0..samp_9 = 1..10.
   - frame_start pulses once.
   - sel steps 0,1,2,3,4 on consecutive cycles with pair_valid=1, then returns to IDLE with sel=0.
2. Same frame, pair_ready=0 for 5 cycles at sel=2:
   - sel holds 2, pair_valid stays 1, samp_x stable.
   - Resumes to 3 once pair_ready returns.
3. Stream 30 samples (values 0..29) with pair_ready held low:
   - Frame 0..9 is presented; frame 10..19 fills and in_ready drops.
   - Samples 20..29 wait.
   - Releasing pair_ready drains 0..9, swaps directly to 10..19 (sel 4 to 0, frame_start pulse), then accepts 20..29.
   - No value is lost or duplicated.
4. Assert rst asynchronously after 6 samples and again mid-drain at sel=3:
   - All outputs return to 0 in the same cycle.
   - The next 10 samples form a clean frame starting at samp_0.
5. With IQ_FRAMER_STATS_EN defined, run 3 frames plus one in_valid during in_ready=0:
   - frame_cnt=3, stall_flag=1.
   - Rebuild without the macro: the design compiles and scenarios 1-4 pass unchanged.
